// File: rtl/mux_n_pipe.sv
`default_nettype none
// ============================================================================
// Module     : mux_n_pipe
// Description: N:1 WIDTH-bit select stage behind a valid/ready output register,
//              with sync flush and a delivered-beat counter.
//              Optional skid entry: define MUX_N_PIPE_SKID_EN.
// Revision   : 1.0 - initial release
// ============================================================================
module mux_n_pipe #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int CNTW  = 16,
  localparam int SELW = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SELW-1:0]    in_sel,
  input  logic [N*WIDTH-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
  output logic               out_err,
  output logic [CNTW-1:0]    beat_cnt
);

  localparam logic [1:0] c_st_empty = 2'd0;
  localparam logic [1:0] c_st_full  = 2'd1;

  logic [WIDTH-1:0] w_ch [N];
  logic [WIDTH-1:0] w_pick_data;
  logic             w_pick_err;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_deliver;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_out_data;
  logic [SELW-1:0]  r_out_sel;
  logic             r_out_err;
  logic [CNTW-1:0]  r_beat_cnt;

  generate
    for (genvar k = 0; k < N; k++) begin : g_ch
      assign w_ch[k] = in_data[k*WIDTH +: WIDTH];
    end
  endgenerate

  // Out-of-range selects produce zero data and raise the error flag.
  always_comb begin
    w_pick_data = '0;
    w_pick_err  = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (in_sel == SELW'(k)) begin
        w_pick_data = w_ch[k];
        w_pick_err  = 1'b0;
      end
    end
  end

  assign w_accept  = in_valid && w_in_ready;
  assign w_deliver = (r_state != c_st_empty) && out_ready;

  assign in_ready  = w_in_ready;
  assign out_valid = (r_state != c_st_empty);
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
  assign out_err   = r_out_err;
  assign beat_cnt  = r_beat_cnt;

`ifdef MUX_N_PIPE_SKID_EN
  localparam logic [1:0] c_st_skid = 2'd2;

  logic [WIDTH-1:0] r_skid_data;
  logic [SELW-1:0]  r_skid_sel;
  logic             r_skid_err;

  // Ready depends only on state and flush, never on out_ready.
  assign w_in_ready = !flush && (r_state != c_st_skid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_st_empty;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_out_err   <= 1'b0;
      r_skid_data <= '0;
      r_skid_sel  <= '0;
      r_skid_err  <= 1'b0;
    end else if (flush) begin
      r_state     <= c_st_empty;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_out_err   <= 1'b0;
      r_skid_data <= '0;
      r_skid_sel  <= '0;
      r_skid_err  <= 1'b0;
    end else begin
      case (r_state)
        c_st_empty: begin
          if (w_accept) begin
            r_out_data <= w_pick_data;
            r_out_sel  <= in_sel;
            r_out_err  <= w_pick_err;
            r_state    <= c_st_full;
          end
        end
        c_st_full: begin
          if (w_accept && w_deliver) begin
            r_out_data <= w_pick_data;
            r_out_sel  <= in_sel;
            r_out_err  <= w_pick_err;
          end else if (w_accept) begin
            r_skid_data <= w_pick_data;
            r_skid_sel  <= in_sel;
            r_skid_err  <= w_pick_err;
            r_state     <= c_st_skid;
          end else if (w_deliver) begin
            r_state <= c_st_empty;
          end
        end
        c_st_skid: begin
          if (w_deliver) begin
            r_out_data <= r_skid_data;
            r_out_sel  <= r_skid_sel;
            r_out_err  <= r_skid_err;
            r_state    <= c_st_full;
          end
        end
        default: r_state <= c_st_empty;
      endcase
    end
  end
`else
  // Stage may refill in the same cycle the held beat leaves.
  assign w_in_ready = !flush && ((r_state == c_st_empty) || out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_st_empty;
      r_out_data <= '0;
      r_out_sel  <= '0;
      r_out_err  <= 1'b0;
    end else if (flush) begin
      r_state    <= c_st_empty;
      r_out_data <= '0;
      r_out_sel  <= '0;
      r_out_err  <= 1'b0;
    end else if (w_accept) begin
      r_out_data <= w_pick_data;
      r_out_sel  <= in_sel;
      r_out_err  <= w_pick_err;
      r_state    <= c_st_full;
    end else if (w_deliver) begin
      r_state <= c_st_empty;
    end
  end
`endif

  // A deliver that coincides with flush still counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt <= '0;
    end else if (w_deliver) begin
      r_beat_cnt <= r_beat_cnt + CNTW'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_n_pipe.sv
`default_nettype none
// Bench for mux_n_pipe: directed table, stall/flush/wrap/reset sequences and
// randomized traffic against a queue-based reference model.
module tb_mux_n_pipe;

  localparam int WIDTH = 32;
  localparam int N     = 3;
  localparam int CNTW  = 4;
  localparam int SELW  = $clog2(N);
`ifdef MUX_N_PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  localparam logic [N*WIDTH-1:0] c_ch = {32'hDEAD_BEEF, 32'h2222_0001, 32'h1111_0000};

  logic               clk;
  logic               rst_n;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [SELW-1:0]    in_sel;
  logic [N*WIDTH-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_sel;
  logic               out_err;
  logic [CNTW-1:0]    beat_cnt;

  mux_n_pipe #(.WIDTH(WIDTH), .N(N), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_err   (out_err),
    .beat_cnt  (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [SELW-1:0]  sel;
    logic             err;
  } beat_t;

  typedef struct {
    logic             v;
    logic [SELW-1:0]  s;
    logic             ordy;
    logic             ov;
    logic [WIDTH-1:0] od;
    logic [SELW-1:0]  os;
    logic             oe;
    logic [CNTW-1:0]  cnt;
  } vec_t;

  beat_t mq[$];
  bit    m_known_zero;
  int    m_cnt;
  int    n_checks;
  int    n_fails;
  vec_t  tbl [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic beat_t pick(input logic [SELW-1:0] s, input logic [N*WIDTH-1:0] d);
    beat_t b;
    b.sel = s;
    if (int'(s) < N) begin
      b.data = d[int'(s)*WIDTH +: WIDTH];
      b.err  = 1'b0;
    end else begin
      b.data = '0;
      b.err  = 1'b1;
    end
    return b;
  endfunction

  task automatic model_check();
    if (mq.size() > 0) begin
      check("out_valid", 64'(out_valid), 64'd1);
      check("out_data", 64'(out_data), 64'(mq[0].data));
      check("out_sel", 64'(out_sel), 64'(mq[0].sel));
      check("out_err", 64'(out_err), 64'(mq[0].err));
    end else begin
      check("out_valid", 64'(out_valid), 64'd0);
      if (m_known_zero) begin
        check("out_data_zero", 64'(out_data), 64'd0);
        check("out_sel_zero", 64'(out_sel), 64'd0);
        check("out_err_zero", 64'(out_err), 64'd0);
      end
    end
    check("beat_cnt", 64'(beat_cnt), 64'(m_cnt));
  endtask

  // One clock: drive, check against the model, clock, advance the model.
  task automatic step(input logic v, input logic [SELW-1:0] s, input logic [N*WIDTH-1:0] d,
                      input logic ordy, input logic fl);
    logic  exp_rdy;
    logic  acc;
    logic  dlv;
    beat_t b;
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #1;
    model_check();
    exp_rdy = !fl && ((CAP == 1) ? (mq.size() == 0 || ordy) : (mq.size() < 2));
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    acc = v && exp_rdy;
    dlv = (mq.size() > 0) && ordy;
    b   = pick(s, d);
    @(posedge clk);
    if (dlv) m_cnt = (m_cnt + 1) % (1 << CNTW);
    if (fl) begin
      mq.delete();
      m_known_zero = 1'b1;
    end else begin
      if (dlv) begin
        void'(mq.pop_front());
        m_known_zero = 1'b0;
      end
      if (acc) mq.push_back(b);
    end
    #1;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    #2;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_sel", 64'(out_sel), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    check("rst_beat_cnt", 64'(beat_cnt), 64'd0);
    mq.delete();
    m_cnt        = 0;
    m_known_zero = 1'b1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks     = 0;
    n_fails      = 0;
    m_cnt        = 0;
    m_known_zero = 1'b1;
    rst_n        = 1'b0;
    flush        = 1'b0;
    in_valid     = 1'b0;
    in_sel       = '0;
    in_data      = '0;
    out_ready    = 1'b0;

    //          v     s     ordy  ov    od              os    oe    cnt
    tbl[0]  = '{1'b1, 2'd2, 1'b1, 1'b1, 32'hDEAD_BEEF, 2'd2, 1'b0, 4'd0};
    tbl[1]  = '{1'b0, 2'd0, 1'b1, 1'b0, 32'h0,         2'd0, 1'b0, 4'd1};
    tbl[2]  = '{1'b1, 2'd0, 1'b1, 1'b1, 32'h1111_0000, 2'd0, 1'b0, 4'd1};
    tbl[3]  = '{1'b1, 2'd1, 1'b1, 1'b1, 32'h2222_0001, 2'd1, 1'b0, 4'd2};
    tbl[4]  = '{1'b1, 2'd2, 1'b1, 1'b1, 32'hDEAD_BEEF, 2'd2, 1'b0, 4'd3};
    tbl[5]  = '{1'b1, 2'd3, 1'b1, 1'b1, 32'h0,         2'd3, 1'b1, 4'd4};
    tbl[6]  = '{1'b1, 2'd0, 1'b1, 1'b1, 32'h1111_0000, 2'd0, 1'b0, 4'd5};
    tbl[7]  = '{1'b1, 2'd1, 1'b1, 1'b1, 32'h2222_0001, 2'd1, 1'b0, 4'd6};
    tbl[8]  = '{1'b1, 2'd2, 1'b1, 1'b1, 32'hDEAD_BEEF, 2'd2, 1'b0, 4'd7};
    tbl[9]  = '{1'b1, 2'd3, 1'b1, 1'b1, 32'h0,         2'd3, 1'b1, 4'd8};
    tbl[10] = '{1'b0, 2'd0, 1'b1, 1'b0, 32'h0,         2'd0, 1'b0, 4'd9};

    #12;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_data", 64'(out_data), 64'd0);
    check("reset_out_sel", 64'(out_sel), 64'd0);
    check("reset_out_err", 64'(out_err), 64'd0);
    check("reset_beat_cnt", 64'(beat_cnt), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single beat, then back-to-back stream including an out-of-range select.
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].v, tbl[i].s, c_ch, tbl[i].ordy, 1'b0);
      check("tbl_out_valid", 64'(out_valid), 64'(tbl[i].ov));
      if (tbl[i].ov) begin
        check("tbl_out_data", 64'(out_data), 64'(tbl[i].od));
        check("tbl_out_sel", 64'(out_sel), 64'(tbl[i].os));
        check("tbl_out_err", 64'(out_err), 64'(tbl[i].oe));
      end
      check("tbl_beat_cnt", 64'(beat_cnt), 64'(tbl[i].cnt));
    end

    // Stall for 3 clocks while full; output must hold.
    step(1'b1, 2'd1, c_ch, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'd2, c_ch, 1'b0, 1'b0);
      check("stall_hold_valid", 64'(out_valid), 64'd1);
      check("stall_hold_data", 64'(out_data), 64'h2222_0001);
    end
    step(1'b0, 2'd0, c_ch, 1'b1, 1'b0);
    check("stall_release_cnt", 64'(beat_cnt), 64'd10);
    step(1'b0, 2'd0, c_ch, 1'b1, 1'b0);
    check("stall_drain_cnt", 64'(beat_cnt), 64'(9 + CAP));

    // Flush while full with a beat offered: nothing accepted, nothing counted.
    step(1'b1, 2'd0, c_ch, 1'b0, 1'b0);
    step(1'b1, 2'd1, c_ch, 1'b0, 1'b1);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_out_data", 64'(out_data), 64'd0);
    check("flush_beat_cnt", 64'(beat_cnt), 64'(9 + CAP));
    // Flush coinciding with a deliver still counts that beat.
    step(1'b1, 2'd2, c_ch, 1'b1, 1'b0);
    step(1'b1, 2'd0, c_ch, 1'b1, 1'b1);
    check("flush_dlv_valid", 64'(out_valid), 64'd0);
    check("flush_dlv_cnt", 64'(beat_cnt), 64'(10 + CAP));

    // Counter wrap: 17 delivers on a 4-bit counter.
    do_reset();
    for (int i = 0; i < 17; i++) step(1'b1, SELW'(i % 4), c_ch, 1'b1, 1'b0);
    step(1'b0, 2'd0, c_ch, 1'b1, 1'b0);
    check("wrap_beat_cnt", 64'(beat_cnt), 64'd1);

    // Reset in the middle of a stall.
    step(1'b1, 2'd2, c_ch, 1'b0, 1'b0);
    step(1'b1, 2'd0, c_ch, 1'b0, 1'b0);
    step(1'b1, 2'd1, c_ch, 1'b0, 1'b0);
    do_reset();
    step(1'b0, 2'd0, c_ch, 1'b1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0,
           SELW'($urandom_range(0, 3)),
           {$urandom(), $urandom(), $urandom()},
           $urandom_range(0, 2) != 0,
           $urandom_range(0, 19) == 0);
    end
    step(1'b0, 2'd0, c_ch, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
